// File: rtl/gray_pkg.sv
// ============================================================================
// Module      : gray_pkg
// Description : Shared width default, FSM state encodings and helper
//               functions for the Gray step counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_pkg;

    localparam int c_width_default = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin_to_gray_enc.sv
// ============================================================================
// Module      : bin_to_gray_enc
// Description : Combinational WIDTH-bit binary-to-Gray encoder (WIDTH <= 32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_gray_enc
    import gray_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = WIDTH'(bin_to_gray(32'(bin)));

endmodule

`default_nettype wire

// File: rtl/gray_step_counter.sv
// ============================================================================
// Module      : gray_step_counter
// Description : Sequenced Gray-code source with programmed/continuous runs,
//               direction control and idle preset. Define GRAY_CHECK_EN to
//               add the sticky single-bit-change checker output gray_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_step_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic [WIDTH-1:0] steps,
    input  logic             up,
    input  logic             stop,
    output logic [WIDTH-1:0] G,
    output logic             busy,
    output logic             done,
    output logic             wrap
`ifdef GRAY_CHECK_EN
    ,
    output logic             gray_err
`endif
);

    state_t           r_state;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rem;

    logic [WIDTH-1:0] w_b_next;
    logic [WIDTH-1:0] w_g_next;
    logic             w_step;
    logic             w_wrap_next;

    always_comb begin
        w_b_next    = r_b;
        w_step      = 1'b0;
        w_wrap_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_b_next = load_val;
                end
            end
            RUN: begin
                if (!stop) begin
                    w_step = 1'b1;
                    if (up) begin
                        w_b_next    = r_b + WIDTH'(1);
                        w_wrap_next = (r_b == {WIDTH{1'b1}});
                    end else begin
                        w_b_next    = r_b - WIDTH'(1);
                        w_wrap_next = (r_b == '0);
                    end
                end
            end
            default: ;
        endcase
    end

    // Gray code is formed from the next count so G changes on the same edge as b.
    bin_to_gray_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .bin  (w_b_next),
        .gray (w_g_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_b     <= '0;
            r_rem   <= '0;
            G       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            r_b  <= w_b_next;
            G    <= w_g_next;
            wrap <= w_wrap_next;
            busy <= (r_state == RUN);
            done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (!load && start) begin
                        r_rem   <= steps;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= IDLE;
                    end else if (r_rem != '0) begin
                        // rem stays 0 in continuous mode, so only programmed runs end here.
                        r_rem <= r_rem - WIDTH'(1);
                        if (r_rem == WIDTH'(1)) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef GRAY_CHECK_EN
    logic [WIDTH-1:0] r_g_prev;
    logic             r_step_chk;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_g_prev   <= '0;
            r_step_chk <= 1'b0;
            gray_err   <= 1'b0;
        end else begin
            r_g_prev   <= G;
            r_step_chk <= w_step;
            if (r_step_chk && (popcount(32'(G ^ r_g_prev)) != 6'd1)) begin
                gray_err <= 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
